// File: rtl/vga_capture.sv
// Single-frame VGA capture engine: samples a pixel-strobed video stream and writes one
// armed frame into a linear {R,G,B} framebuffer, flagging malformed lines and frames.
module vga_capture #(
  parameter int unsigned H_ACTIVE = 200,
  parameter int unsigned V_ACTIVE = 600
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        vid_hs_n,
  input  logic        vid_vs_n,
  input  logic        vid_blank_n,
  input  logic [7:0]  vid_r,
  input  logic [7:0]  vid_g,
  input  logic [7:0]  vid_b,
  input  logic        cap_start,
  output logic [23:0] fb_d,
  output logic [16:0] fb_adr,
  output logic        fb_we,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        line_err,
  output logic        frame_err
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] XMax    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] YMax    = YW'(V_ACTIVE);
  localparam logic [16:0]   RowStep = 17'(H_ACTIVE);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic          hs_prev_q, vs_prev_q;
  logic [XW-1:0] x_q, x_d, x_cnt;
  logic [YW-1:0] y_q, y_d, y_new;
  // Base address of the current line (y*H_ACTIVE), advanced on each line close.
  logic [16:0]   row_q, row_d;
  logic          line_err_d, frame_err_d;
  logic          we_d;
  logic [23:0]   d_d;
  logic [16:0]   adr_d;
  logic          hs_fall, vs_fall, pix_active, pix_write;

  assign hs_fall    = pix_en & hs_prev_q & ~vid_hs_n;
  assign vs_fall    = pix_en & vs_prev_q & ~vid_vs_n;
  assign pix_active = pix_en & vid_blank_n & (state_q == StCapture);
  assign pix_write  = pix_active & (x_q < XMax);

  assign cap_busy = (state_q == StArmed) || (state_q == StCapture);
  assign cap_done = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    row_d       = row_q;
    line_err_d  = line_err;
    frame_err_d = frame_err;
    we_d        = 1'b0;
    d_d         = fb_d;
    adr_d       = fb_adr;
    x_cnt       = x_q;
    y_new       = y_q;

    unique case (state_q)
      StIdle: begin
        if (cap_start) begin
          state_d     = StArmed;
          line_err_d  = 1'b0;
          frame_err_d = 1'b0;
        end
      end

      StArmed: begin
        if (vs_fall) begin
          state_d = StCapture;
          x_d     = '0;
          y_d     = '0;
          row_d   = '0;
        end
      end

      StCapture: begin
        if (pix_write) begin
          we_d  = 1'b1;
          d_d   = {vid_r, vid_g, vid_b};
          adr_d = row_q + 17'(x_q);
          x_cnt = x_q + 1'b1;
        end else if (pix_active) begin
          line_err_d = 1'b1;
        end
        x_d = x_cnt;

        // Line close is evaluated before the vsync check so a coincident edge pair
        // still counts the final line.
        if (hs_fall && (x_cnt != '0)) begin
          if (x_cnt != XMax) line_err_d = 1'b1;
          x_d   = '0;
          y_new = y_q + 1'b1;
          row_d = row_q + RowStep;
        end
        y_d = y_new;

        if (y_new == YMax) begin
          state_d = StDone;
        end else if (vs_fall) begin
          frame_err_d = 1'b1;
          state_d     = StDone;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StIdle;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      row_q     <= '0;
      fb_we     <= 1'b0;
      fb_d      <= '0;
      fb_adr    <= '0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pix_en) begin
        hs_prev_q <= vid_hs_n;
        vs_prev_q <= vid_vs_n;
      end
      x_q       <= x_d;
      y_q       <= y_d;
      row_q     <= row_d;
      fb_we     <= we_d;
      fb_d      <= d_d;
      fb_adr    <= adr_d;
      line_err  <= line_err_d;
      frame_err <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Randomised frame-level bench for vga_capture: an event-driven reference model predicts
// every framebuffer write and flag state; a monitor checks writes against the queue.
module tb_vga_capture;

  localparam int unsigned H = 10;
  localparam int unsigned V = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        vid_hs_n = 1'b1;
  logic        vid_vs_n = 1'b1;
  logic        vid_blank_n = 1'b0;
  logic [7:0]  vid_r = '0, vid_g = '0, vid_b = '0;
  logic        cap_start = 1'b0;
  logic [23:0] fb_d;
  logic [16:0] fb_adr;
  logic        fb_we, cap_busy, cap_done, line_err, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .vid_hs_n   (vid_hs_n),
    .vid_vs_n   (vid_vs_n),
    .vid_blank_n(vid_blank_n),
    .vid_r      (vid_r),
    .vid_g      (vid_g),
    .vid_b      (vid_b),
    .cap_start  (cap_start),
    .fb_d       (fb_d),
    .fb_adr     (fb_adr),
    .fb_we      (fb_we),
    .cap_busy   (cap_busy),
    .cap_done   (cap_done),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: capture status in terms of frame/line events only.
  typedef enum {MIdle, MArmed, MCap} mst_e;
  typedef struct {
    logic [16:0] adr;
    logic [23:0] d;
    int          due;
  } wr_t;

  wr_t  exp_q[$];
  mst_e m_st = MIdle;
  int   m_x = 0, m_y = 0;
  bit   m_lerr = 0, m_ferr = 0;
  int   exp_done = 0, seen_done = 0;
  bit   p_hs = 1, p_vs = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_arm();
    if (m_st == MIdle) begin
      m_st   = MArmed;
      m_lerr = 0;
      m_ferr = 0;
    end
  endfunction

  function automatic void m_pixel(input logic [23:0] px, input int due);
    wr_t w;
    if (m_st != MCap) return;
    if (m_x < int'(H)) begin
      w.adr = 17'(m_x + m_y * int'(H));
      w.d   = px;
      w.due = due;
      exp_q.push_back(w);
      m_x++;
    end else begin
      m_lerr = 1;
    end
  endfunction

  function automatic void m_close();
    if (m_st != MCap || m_x == 0) return;
    if (m_x != int'(H)) m_lerr = 1;
    m_x = 0;
    m_y++;
    if (m_y == int'(V)) begin
      m_st = MIdle;
      exp_done++;
    end
  endfunction

  function automatic void m_vsync();
    if (m_st == MCap) begin
      m_ferr = 1;
      m_st   = MIdle;
      exp_done++;
    end else if (m_st == MArmed) begin
      m_st = MCap;
      m_x  = 0;
      m_y  = 0;
    end
  endfunction

  function automatic void m_reset();
    m_st   = MIdle;
    m_x    = 0;
    m_y    = 0;
    m_lerr = 0;
    m_ferr = 0;
    p_hs   = 1;
    p_vs   = 1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fb_we"},     32'(fb_we),     32'd0);
    chk({tag, "_fb_d"},      32'(fb_d),      32'd0);
    chk({tag, "_fb_adr"},    32'(fb_adr),    32'd0);
    chk({tag, "_cap_busy"},  32'(cap_busy),  32'd0);
    chk({tag, "_cap_done"},  32'(cap_done),  32'd0);
    chk({tag, "_line_err"},  32'(line_err),  32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // One pix_en slot followed by a random idle gap of 1..3 cycles.
  task automatic slot(input bit hs, input bit vs, input bit blank, input logic [23:0] px,
                      input bit do_rst);
    @(posedge clk); #1;
    pix_en      = 1'b1;
    vid_hs_n    = hs;
    vid_vs_n    = vs;
    vid_blank_n = blank;
    {vid_r, vid_g, vid_b} = px;
    reset       = do_rst;
    if (do_rst) begin
      m_reset();
    end else begin
      if (blank) m_pixel(px, cyc + 1);
      if (p_hs && !hs) m_close();
      if (p_vs && !vs) m_vsync();
      p_hs = hs;
      p_vs = vs;
    end
    @(posedge clk); #1;
    pix_en = 1'b0;
    reset  = 1'b0;
    if (do_rst) chk_reset_outputs("mid_reset");
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic arm();
    @(posedge clk); #1;
    cap_start = 1'b1;
    m_arm();
    @(posedge clk); #1;
    cap_start = 1'b0;
  endtask

  // Frame: combined hs/vs sync, nlines video lines (line bad_line carries bad_cnt pixels),
  // then two blank lines. Optional cap_start before line arm_at, reset at line rst_at.
  task automatic send_frame(input int nlines, input int bad_line, input int bad_cnt,
                            input int arm_at, input int rst_at);
    int cnt;
    logic [23:0] px;
    slot(0, 0, 0, 24'h0, 0);
    slot(0, 0, 0, 24'h0, 0);
    slot(1, 1, 0, 24'h0, 0);
    for (int l = 0; l < nlines + 2; l++) begin
      if (l > 0) begin
        slot(0, 1, 0, 24'h0, 0);
        slot(0, 1, 0, 24'h0, 0);
        slot(1, 1, 0, 24'h0, 0);
      end
      if (l == arm_at) arm();
      cnt = (l >= nlines) ? 0 : ((l == bad_line) ? bad_cnt : int'(H));
      for (int p = 0; p < cnt; p++) begin
        px = 24'($urandom);
        if (l == 3 && p == 7) px = 24'h123456;
        slot(1, 1, 1, px, (l == rst_at) && (p == 2));
      end
      slot(1, 1, 0, 24'h0, 0);
    end
  endtask

  task automatic frame_check(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_line_err"},  32'(line_err),  32'(m_lerr));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "_cap_busy"},  32'(cap_busy),  32'(m_st != MIdle));
    chk({tag, "_done_cnt"},  32'(seen_done), 32'(exp_done));
  endtask

  // Monitor: every fb_we must match the head of the expected-write queue.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk); #2;
      if (cap_done === 1'b1) seen_done++;
      if (fb_we !== 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_fb_we", 32'(fb_we), 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("fb_adr", 32'(fb_adr), 32'(w.adr));
          chk("fb_d", 32'(fb_d), 32'(w.d));
          chk("we_cycle", 32'(cyc), 32'(w.due));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nl, bad, bcnt, arm_at;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;

    send_frame(V, -1, 0, -1, -1);
    frame_check("no_arm");
    arm();
    send_frame(V, -1, 0, -1, -1);
    frame_check("full");
    arm();
    send_frame(V, 2, H + 1, -1, -1);
    frame_check("long_line");
    arm();
    send_frame(V, 4, H - 3, -1, -1);
    frame_check("short_line");
    arm();
    send_frame(3, -1, 0, -1, -1);
    frame_check("short_frame");
    arm();
    send_frame(V, -1, 0, -1, -1);
    frame_check("early_vsync");
    send_frame(V, -1, 0, 3, -1);
    frame_check("mid_arm");
    send_frame(V, -1, 0, -1, -1);
    frame_check("after_mid_arm");
    arm();
    send_frame(V, -1, 0, -1, 2);
    frame_check("reset_abort");
    arm();
    send_frame(V, -1, 0, -1, -1);
    frame_check("rearm");

    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 1) == 1) arm();
      nl     = int'(V) - 2 + int'($urandom_range(0, 3));
      bad    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      bcnt   = int'($urandom_range(0, H + 2));
      arm_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl)) : -1;
      send_frame(nl, bad, bcnt, arm_at, -1);
      frame_check("random");
    end

    repeat (10) @(posedge clk);
    #1;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 200, active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 600, active lines per frame.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pix_en  input  1  pixel strobe, one CLOCK_50 cycle wide; video inputs are valid only when high.
REQ-007 vid_hs_n  input  1  horizontal sync, active low.
REQ-008 vid_vs_n  input  1  vertical sync, active low.
REQ-009 vid_blank_n  input  1  high = active pixel.
REQ-010 vid_r, vid_g, vid_b  input  8 each  pixel colour.
REQ-011 cap_start  input  1  one-cycle pulse that arms capture of the next frame.
REQ-012 fb_d  output  24  write data {R,G,B}, with R in [23:16], G in [15:8] and B in [7:0].
REQ-013 fb_adr  output  17  write address = x + y*H_ACTIVE.
REQ-014 fb_we  output  1  framebuffer write strobe, active high.
REQ-015 cap_busy  output  1  high in ARMED and CAPTURE.
REQ-016 cap_done  output  1  one-cycle pulse at the end of a frame.
REQ-017 line_err  output  1  sticky; a line had a pixel count other than H_ACTIVE.
REQ-018 frame_err  output  1  sticky; vsync arrived before V_ACTIVE lines were captured.

Function
REQ-019 The block SHALL sample sync and blank inputs only on pix_en cycles.
REQ-020 Previous-sample registers for hs_n and vs_n SHALL reset to 1.
REQ-021 A sync edge SHALL be detected as previous sample = 1 and current sample = 0.
REQ-022 The FSM states SHALL be IDLE, ARMED, CAPTURE and DONE.
REQ-023 IDLE -> ARMED on cap_start; cap_start SHALL be ignored in every other state.
REQ-024 On entry to ARMED, line_err and frame_err SHALL clear.
REQ-025 ARMED -> CAPTURE on a vs_n falling edge; x and y SHALL be set to 0.
REQ-026 In CAPTURE, a pix_en cycle with vid_blank_n=1 and x<H_ACTIVE SHALL write the pixel at address x + y*H_ACTIVE, then increment x.
REQ-027 A write SHALL assert fb_we for exactly one cycle, one cycle after the pix_en cycle, with fb_d and fb_adr valid in that cycle.
REQ-028 Active pixels arriving when x=H_ACTIVE SHALL NOT be written and SHALL set line_err.
REQ-029 An hs_n falling edge in CAPTURE with x>0 SHALL close the line: line_err is set if x != H_ACTIVE, then x resets to 0 and y increments.
REQ-030 An hs_n falling edge with x=0 SHALL be ignored, so blank lines are not counted.
REQ-031 When y reaches V_ACTIVE, the block SHALL go CAPTURE -> DONE.
REQ-032 A vs_n falling edge in CAPTURE with y<V_ACTIVE SHALL set frame_err and go to DONE.
REQ-033 If hs_n and vs_n edges occur in the same pix_en cycle, the line close SHALL be processed first, then the vsync check.
REQ-034 DONE SHALL pulse cap_done for one cycle and then return to IDLE.
REQ-035 The address product SHALL be computed at 17 bits; the maximum address is H_ACTIVE*V_ACTIVE-1 = 119999.
REQ-036 A pix_en cycle outside CAPTURE SHALL produce no write.

Reset
REQ-037 Reset SHALL force IDLE, x=0, y=0, fb_we=0, fb_d=0, fb_adr=0, cap_busy=0, cap_done=0, line_err=0 and frame_err=0, effective the next rising edge.
REQ-038 Reset asserted mid-capture SHALL abort with no further writes; a pending fb_we SHALL be cancelled.

Verification
REQ-039 Full frame: pix_en every 5 cycles, 264-pixel lines with 200 active, 628 lines, cap_start before vsync -> exactly 120000 writes, first at fb_adr=0 and last at 119999, one cap_done pulse, both error flags 0.
REQ-040 Pixel (x=7, y=3) = 0x123456 -> fb_we with fb_adr=607 and fb_d=0x123456, one cycle after its pix_en.
REQ-041 Line of 201 active pixels -> 200 writes for that line, line_err=1, next line starts at x=0.
REQ-042 Vsync after 300 lines -> frame_err=1, cap_done pulse, IDLE, no further writes.
REQ-043 Video running with no cap_start -> fb_we never asserts; cap_start mid-frame -> capture begins at the next vsync with fb_adr=0.
REQ-044 Reset asserted at line 100 -> all outputs at reset values next cycle and no writes until re-armed.
